// File: rtl/ems_window_controller.sv
`default_nettype none
// ============================================================================
// Module      : ems_window_controller
// Description : Expanded-memory window controller. Four I/O-mapped page
//               registers map a 64 KB upper-memory window onto four 16 KB
//               banks of a larger backing store. Window accesses are
//               forwarded over a request/acknowledge port. The bus cycle is
//               stretched through io_channel_ready until the store answers.
// Ports       : clock, reset_n           - clock, async active-low reset
//               address, internal_data_bus - latched bus address / write data
//               io_*_n, memory_*_n       - active-low bus commands
//               address_enable_n         - low while DMA owns the bus
//               data_bus_out(_enable)    - read data back to the chipset
//               io_channel_ready         - low inserts wait states
//               ems_*                    - backing-store request port
// Revision    : 1.0 - initial release
// ============================================================================
module ems_window_controller #(
  parameter logic [9:0] IO_BASE        = 10'h260,
  parameter logic [3:0] WINDOW_SEGMENT = 4'hD,
  parameter int         PAGE_BITS      = 7,
  parameter int         TIMEOUT        = 255
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [19:0]           address,
  input  logic [7:0]            internal_data_bus,
  input  logic                  io_read_n,
  input  logic                  io_write_n,
  input  logic                  memory_read_n,
  input  logic                  memory_write_n,
  input  logic                  address_enable_n,
  output logic [7:0]            data_bus_out,
  output logic                  data_bus_out_enable,
  output logic                  io_channel_ready,
  output logic [PAGE_BITS+13:0] ems_address,
  output logic                  ems_request,
  output logic                  ems_write,
  output logic [7:0]            ems_write_data,
  input  logic                  ems_ack,
  input  logic [7:0]            ems_read_data
);

  localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_HOLD = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]           pr_q [4];
  logic [PAGE_BITS+13:0] ems_address_q;
  logic                 ems_write_q;
  logic [7:0]           ems_wdata_q;
  logic [7:0]           rdata_q;

  // Two samples of each command: s1 is the registered command, s2 the one
  // before it. A falling edge is s1 low with s2 still high.
  logic iow_s1_q, iow_s2_q;
  logic mrd_s1_q, mrd_s2_q;
  logic mwr_s1_q, mwr_s2_q;

  logic       w_iow_edge, w_mrd_edge, w_mwr_edge;
  logic       w_io_decode, w_io_rd;
  logic [7:0] w_sel_pr;
  logic       w_win_hit, w_mem_cmd_low, w_start, w_orig_low, w_tmo;

  assign w_iow_edge    = ~iow_s1_q & iow_s2_q;
  assign w_mrd_edge    = ~mrd_s1_q & mrd_s2_q;
  assign w_mwr_edge    = ~mwr_s1_q & mwr_s2_q;

  // DMA cycles never touch the page registers; upper address bits are not
  // decoded so the ports alias throughout the I/O space.
  assign w_io_decode   = address_enable_n & (address[9:2] == IO_BASE[9:2]);
  assign w_io_rd       = w_io_decode & ~io_read_n;

  assign w_sel_pr      = pr_q[address[15:14]];
  assign w_win_hit     = (address[19:16] == WINDOW_SEGMENT) & w_sel_pr[7];
  assign w_mem_cmd_low = ~memory_read_n | ~memory_write_n;
  assign w_start       = (state_q == c_IDLE) & (w_mrd_edge | w_mwr_edge) & w_win_hit;
  // Tracks the command that started the current access, not any command.
  assign w_orig_low    = ems_write_q ? ~memory_write_n : ~memory_read_n;
  assign w_tmo         = (cnt_q == c_TIMEOUT);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= c_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      c_IDLE: begin
        if (w_start) state_d = c_REQ;
      end
      c_REQ: begin
        if (ems_ack || w_tmo) begin
          // A released command means the access was aborted: nothing to hold.
          state_d = w_orig_low ? c_HOLD : c_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_HOLD: begin
        if (!w_orig_low) state_d = c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    ems_request         = 1'b0;
    io_channel_ready    = 1'b1;
    data_bus_out        = 8'h00;
    data_bus_out_enable = 1'b0;
    if (state_q == c_REQ) begin
      ems_request      = 1'b1;
      io_channel_ready = 1'b0;
    end
    // Stall from the very first command cycle, before the edge is registered.
    if ((state_q == c_IDLE) && w_win_hit && w_mem_cmd_low) begin
      io_channel_ready = 1'b0;
    end
    if (w_io_rd) begin
      data_bus_out        = pr_q[address[1:0]];
      data_bus_out_enable = 1'b1;
    end else if ((state_q == c_HOLD) && !ems_write_q) begin
      data_bus_out        = rdata_q;
      data_bus_out_enable = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Command samplers, page registers and access latches
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      iow_s1_q <= 1'b1;
      iow_s2_q <= 1'b1;
      mrd_s1_q <= 1'b1;
      mrd_s2_q <= 1'b1;
      mwr_s1_q <= 1'b1;
      mwr_s2_q <= 1'b1;
    end else begin
      iow_s1_q <= io_write_n;
      iow_s2_q <= iow_s1_q;
      mrd_s1_q <= memory_read_n;
      mrd_s2_q <= mrd_s1_q;
      mwr_s1_q <= memory_write_n;
      mwr_s2_q <= mwr_s1_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) pr_q[i] <= 8'h00;
    end else if (w_iow_edge && w_io_decode) begin
      pr_q[address[1:0]] <= internal_data_bus;
    end
  end

  // Latched once at access start so later page-register writes cannot
  // redirect an in-flight access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ems_address_q <= '0;
      ems_write_q   <= 1'b0;
      ems_wdata_q   <= 8'h00;
      rdata_q       <= 8'h00;
    end else begin
      if (w_start) begin
        ems_address_q <= {w_sel_pr[PAGE_BITS-1:0], address[13:0]};
        ems_write_q   <= w_mwr_edge;
        if (w_mwr_edge) ems_wdata_q <= internal_data_bus;
      end
      if (state_q == c_REQ) begin
        if (ems_ack)    rdata_q <= ems_read_data;
        else if (w_tmo) rdata_q <= 8'hFF;
      end
    end
  end

  assign ems_address    = ems_address_q;
  assign ems_write      = ems_write_q;
  assign ems_write_data = ems_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ems_window_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ems_window_controller
// Description : Directed self-checking bench for ems_window_controller.
//               Inputs change 1 ns after the rising edge; "cycle k" of a
//               scenario is the interval following the k-th edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ems_window_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [19:0] address;
  logic [7:0]  internal_data_bus;
  logic        io_read_n, io_write_n, memory_read_n, memory_write_n;
  logic        address_enable_n;
  logic [7:0]  data_bus_out;
  logic        data_bus_out_enable, io_channel_ready;
  logic [20:0] ems_address;
  logic        ems_request, ems_write;
  logic [7:0]  ems_write_data;
  logic        ems_ack;
  logic [7:0]  ems_read_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  ems_window_controller dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .address             (address),
    .internal_data_bus   (internal_data_bus),
    .io_read_n           (io_read_n),
    .io_write_n          (io_write_n),
    .memory_read_n       (memory_read_n),
    .memory_write_n      (memory_write_n),
    .address_enable_n    (address_enable_n),
    .data_bus_out        (data_bus_out),
    .data_bus_out_enable (data_bus_out_enable),
    .io_channel_ready    (io_channel_ready),
    .ems_address         (ems_address),
    .ems_request         (ems_request),
    .ems_write           (ems_write),
    .ems_write_data      (ems_write_data),
    .ems_ack             (ems_ack),
    .ems_read_data       (ems_read_data)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic io_write(input logic [19:0] a, input logic [7:0] d, input logic aen_n);
    address = a; internal_data_bus = d; address_enable_n = aen_n; io_write_n = 1'b0;
    step(); step();
    io_write_n = 1'b1; address_enable_n = 1'b1;
    step(); step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; address = '0; internal_data_bus = '0;
    io_read_n = 1'b1; io_write_n = 1'b1; memory_read_n = 1'b1; memory_write_n = 1'b1;
    address_enable_n = 1'b1; ems_ack = 1'b0; ems_read_data = '0;
    step(); step();
    n_checks++; if (ems_request !== 1'b0) begin n_fail++; $display("FAIL reset_request: got %h want 0", ems_request); end
    n_checks++; if (io_channel_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %h want 1", io_channel_ready); end
    n_checks++; if (data_bus_out_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %h want 0", data_bus_out_enable); end
    n_checks++; if (data_bus_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data_bus_out); end
    n_checks++; if (ems_address !== 21'h0) begin n_fail++; $display("FAIL reset_ems_address: got %h want 0", ems_address); end
    n_checks++; if (ems_write !== 1'b0 || ems_write_data !== 8'h00) begin n_fail++; $display("FAIL reset_write: got %h/%h want 0/00", ems_write, ems_write_data); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_io();
    // Page register 3 still holds its reset value
    address = 20'h00263; io_read_n = 1'b0; #1;
    n_checks++; if (data_bus_out !== 8'h00 || data_bus_out_enable !== 1'b1) begin n_fail++; $display("FAIL io_read_263_reset: got %h en %h want 00 en 1", data_bus_out, data_bus_out_enable); end
    io_read_n = 1'b1;
    step();
    io_write(20'h00262, 8'h85, 1'b1);
    address = 20'h00262; io_read_n = 1'b0; #1;
    n_checks++; if (data_bus_out !== 8'h85 || data_bus_out_enable !== 1'b1) begin n_fail++; $display("FAIL io_read_262: got %h en %h want 85 en 1", data_bus_out, data_bus_out_enable); end
    n_checks++; if (io_channel_ready !== 1'b1) begin n_fail++; $display("FAIL io_read_ready: got %h want 1", io_channel_ready); end
    // Upper address bits are not decoded
    address = 20'hFC262; #1;
    n_checks++; if (data_bus_out !== 8'h85) begin n_fail++; $display("FAIL io_read_alias: got %h want 85", data_bus_out); end
    // Wrong base: no drive
    address = 20'h00362; #1;
    n_checks++; if (data_bus_out_enable !== 1'b0) begin n_fail++; $display("FAIL io_read_miss_enable: got %h want 0", data_bus_out_enable); end
    io_read_n = 1'b1;
    step();
  endtask

  task automatic test_mem_read();
    int low_cnt = 0;
    io_write(20'h00261, 8'h83, 1'b1);
    address = 20'hD4123; memory_read_n = 1'b0;
    for (int c = 0; c < 10; c++) begin
      ems_ack = (c == 4); ems_read_data = (c == 4) ? 8'h5A : 8'h00;
      if (c == 8) memory_read_n = 1'b1;
      #1;
      if (!io_channel_ready) low_cnt++;
      if (c == 2) begin
        n_checks++; if (ems_request !== 1'b1) begin n_fail++; $display("FAIL rd_request: got %h want 1", ems_request); end
        n_checks++; if (ems_address !== 21'h0C123) begin n_fail++; $display("FAIL rd_ems_address: got %h want 0c123", ems_address); end
        n_checks++; if (ems_write !== 1'b0) begin n_fail++; $display("FAIL rd_ems_write: got %h want 0", ems_write); end
      end
      if (c == 5 || c == 8) begin
        n_checks++; if (data_bus_out !== 8'h5A || data_bus_out_enable !== 1'b1) begin n_fail++; $display("FAIL rd_data_c%0d: got %h en %h want 5a en 1", c, data_bus_out, data_bus_out_enable); end
        n_checks++; if (ems_request !== 1'b0) begin n_fail++; $display("FAIL rd_request_drop_c%0d: got %h want 0", c, ems_request); end
      end
      if (c == 9) begin
        n_checks++; if (data_bus_out_enable !== 1'b0) begin n_fail++; $display("FAIL rd_release_enable: got %h want 0", data_bus_out_enable); end
      end
      step();
    end
    ems_ack = 1'b0;
    n_checks++; if (low_cnt != 5) begin n_fail++; $display("FAIL rd_ready_low_cycles: got %0d want 5", low_cnt); end
  endtask

  task automatic test_mem_write();
    logic en_seen = 1'b0;
    io_write(20'h00260, 8'h80, 1'b1);
    address = 20'hD0010; internal_data_bus = 8'hA7; memory_write_n = 1'b0;
    for (int c = 0; c < 9; c++) begin
      ems_ack = (c == 2);
      if (c == 5) memory_write_n = 1'b1;
      #1;
      if (data_bus_out_enable) en_seen = 1'b1;
      if (c == 2) begin
        n_checks++; if (ems_request !== 1'b1 || ems_write !== 1'b1) begin n_fail++; $display("FAIL wr_req_write: got %h/%h want 1/1", ems_request, ems_write); end
        n_checks++; if (ems_write_data !== 8'hA7) begin n_fail++; $display("FAIL wr_data: got %h want a7", ems_write_data); end
        n_checks++; if (ems_address !== 21'h00010) begin n_fail++; $display("FAIL wr_ems_address: got %h want 00010", ems_address); end
      end
      if (c == 3) begin
        n_checks++; if (io_channel_ready !== 1'b1 || ems_request !== 1'b0) begin n_fail++; $display("FAIL wr_earliest_ack: ready %h req %h want 1/0", io_channel_ready, ems_request); end
      end
      step();
    end
    ems_ack = 1'b0;
    n_checks++; if (en_seen !== 1'b0) begin n_fail++; $display("FAIL wr_enable_seen: got %h want 0", en_seen); end
  endtask

  task automatic test_disabled();
    logic req_seen = 1'b0, stall_seen = 1'b0, en_seen = 1'b0;
    io_write(20'h00262, 8'h05, 1'b1);
    address = 20'hD8000; memory_read_n = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (ems_request) req_seen = 1'b1;
      if (!io_channel_ready) stall_seen = 1'b1;
      if (data_bus_out_enable) en_seen = 1'b1;
      step();
    end
    memory_read_n = 1'b1;
    step(); step();
    n_checks++; if (req_seen !== 1'b0) begin n_fail++; $display("FAIL dis_request: got %h want 0", req_seen); end
    n_checks++; if (stall_seen !== 1'b0) begin n_fail++; $display("FAIL dis_stall: got %h want 0", stall_seen); end
    n_checks++; if (en_seen !== 1'b0) begin n_fail++; $display("FAIL dis_enable: got %h want 0", en_seen); end
  endtask

  task automatic test_abort();
    address = 20'hD4000; memory_read_n = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) memory_read_n = 1'b1;
      ems_ack = (c == 5); ems_read_data = 8'h3C;
      #1;
      if (c == 4) begin
        n_checks++; if (ems_request !== 1'b1) begin n_fail++; $display("FAIL abort_request_held: got %h want 1", ems_request); end
      end
      if (c == 6 || c == 7) begin
        n_checks++; if (ems_request !== 1'b0 || io_channel_ready !== 1'b1 || data_bus_out_enable !== 1'b0) begin n_fail++; $display("FAIL abort_idle_c%0d: req %h ready %h en %h want 0/1/0", c, ems_request, io_channel_ready, data_bus_out_enable); end
      end
      step();
    end
    ems_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int req_cnt = 0;
    address = 20'hD4000; memory_read_n = 1'b0;
    for (int c = 0; c < 270; c++) begin
      if (c == 262) memory_read_n = 1'b1;
      #1;
      if (ems_request) req_cnt++;
      if (c == 258) begin
        n_checks++; if (io_channel_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_ready: got %h want 1", io_channel_ready); end
        n_checks++; if (data_bus_out !== 8'hFF || data_bus_out_enable !== 1'b1) begin n_fail++; $display("FAIL tmo_data: got %h en %h want ff en 1", data_bus_out, data_bus_out_enable); end
      end
      step();
    end
    n_checks++; if (req_cnt != 256) begin n_fail++; $display("FAIL tmo_request_cycles: got %0d want 256", req_cnt); end
  endtask

  task automatic test_reset_mid();
    address = 20'hD4000; memory_read_n = 1'b0;
    step(); step(); step();
    #1;
    n_checks++; if (ems_request !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_request: got %h want 1", ems_request); end
    #2; reset_n = 1'b0; #1;
    n_checks++; if (ems_request !== 1'b0 || io_channel_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_async: req %h ready %h want 0/1", ems_request, io_channel_ready); end
    memory_read_n = 1'b1; address = 20'h00261; io_read_n = 1'b0; #1;
    n_checks++; if (data_bus_out !== 8'h00) begin n_fail++; $display("FAIL rst_mid_pr_cleared: got %h want 00", data_bus_out); end
    io_read_n = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    io_write(20'h00262, 8'h77, 1'b0);
    address = 20'h00262; io_read_n = 1'b0; #1;
    n_checks++; if (data_bus_out !== 8'h00) begin n_fail++; $display("FAIL dma_io_write_ignored: got %h want 00", data_bus_out); end
    io_read_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_io();
    test_mem_read();
    test_mem_write();
    test_disabled();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ems_window_controller.md
# ems_window_controller

Expanded-memory (LIM EMS style) board controller on the chipset's external I/O channel, downstream of the bus arbiter's address, command and data outputs. It maps a 64 KB window at a fixed upper-memory segment onto four independently pageable 16 KB banks of a larger backing store, using a request/acknowledge port. It stretches bus cycles through `io_channel_ready` until the backing store answers. Read data returns to the chipset data-bus mux via `data_bus_out` / `data_bus_out_enable`.

## Interface
- `IO_BASE`, default 10'h260: I/O base; four consecutive ports (base+0..3) hold page registers 0..3.
- `WINDOW_SEGMENT`, default 4'hD: window sits at address[19:16] == this value (0xD0000–0xDFFFF).
- `PAGE_BITS`, default 7: backing-store page-number width (128 × 16 KB = 2 MB).
- `TIMEOUT`, default 255: cycles to wait for `ems_ack` before abandoning a window access.
- `clock` input 1: system clock; all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `address` input 20: latched bus address.
- `internal_data_bus` input 8: bus write data.
- `io_read_n`, `io_write_n`, `memory_read_n`, `memory_write_n` input 1 each: bus commands, active-low.
- `address_enable_n` input 1: low = DMA owns the bus. I/O decode is ignored while low. Window decode is allowed.
- `data_bus_out` output 8: read data, for page registers or the window.
- `data_bus_out_enable` output 1: high while this block drives read data.
- `io_channel_ready` output 1: low = insert wait states.
- `ems_address` output PAGE_BITS+14: backing-store byte address {page, address[13:0]}.
- `ems_request` output 1: access request, level.
- `ems_write` output 1: 1 = write, 0 = read; valid with request.
- `ems_write_data` output 8: write data; valid with request.
- `ems_ack` input 1: one-cycle completion pulse.
- `ems_read_data` input 8: valid in the `ems_ack` cycle.

## Operation
- Page registers `pr[0..3]`, 8 bits each: bit 7 = enable, bits [PAGE_BITS-1:0] = page. Unused bits are stored and read back. Reset value 0x00.
- I/O decode:
  - Decode condition: `address_enable_n`=1, address[9:2]==IO_BASE[9:2], address[19:10] ignored.
  - Write: on the `io_write_n` falling edge, `pr[address[1:0]]` is loaded from `internal_data_bus`.
  - Read: while `io_read_n`=0, `data_bus_out`=`pr[address[1:0]]` combinationally and `data_bus_out_enable`=1. No wait states.
- Window hit: address[19:16]==WINDOW_SEGMENT and `pr[address[15:14]]` bit 7 = 1. If the selected page is disabled, the block ignores the cycle: no drive, ready stays 1.
- Commands are registered once for falling-edge detection. The edge cycle is the cycle in which the sampled command is low and the previous sample was high.
- FSM states:
  - IDLE
    - On a memory command edge with a window hit: latch `ems_address`={pr[sel][PAGE_BITS-1:0], address[13:0]}, latch `ems_write`, and latch `ems_write_data`=`internal_data_bus` for writes.
    - Clear the timeout counter and go to REQ.
  - REQ
    - `ems_request`=1.
    - On `ems_ack`: latch `ems_read_data` into the read latch and drop the request. Go to HOLD if the command is still low, otherwise IDLE.
    - Otherwise increment the counter. When the counter reaches TIMEOUT, drop the request, set the read latch to 0xFF and go to HOLD.
  - HOLD
    - Stay until the originating command goes high, then go to IDLE.
    - `data_bus_out_enable`=1 for reads; `data_bus_out`=read latch.
- `io_channel_ready`=0 while the state is REQ, or while the state is IDLE with a window-hit memory command low. This is combinational so the command's first cycle already stalls. Otherwise 1.
- Command released during REQ (abort): the request is held until ack or timeout, then the FSM goes directly to IDLE. No data is driven.
- Page-register writes during REQ/HOLD do not alter the latched `ems_address`.

## Timing
- Reset values:
  - `ems_request`=0, `ems_write`=0, `ems_address`=0, `ems_write_data`=0.
  - `data_bus_out`=0x00, `data_bus_out_enable`=0, `io_channel_ready`=1.
  - All `pr`=0x00, FSM=IDLE, counter=0.
- Cycle numbering:
  - cycle 0: command low.
  - cycle 1: edge detected, FSM leaves IDLE.
  - cycle 2: `ems_request` high.
  - Earliest ack: cycle 2, giving HOLD and `io_channel_ready`=1 in cycle 3.
- Ack latency N cycles after the request rises gives ready back N+1 cycles after it.
- Timeout: the request is high for exactly TIMEOUT+1 cycles, then drops, followed by HOLD.
- Ack arriving while not in REQ is ignored.
- `reset_n` asserted mid-access clears everything immediately (asynchronously). The backing store must tolerate a dropped request.

## Test plan
- I/O write 0x85 to 0x262, then read 0x262 → `data_bus_out`=0x85 with enable high. A read of 0x263 after reset → 0x00. No ready stall.
- `pr[1]`=0x83; memory read of 0xD4123; ack with 0x5A after 3 cycles → `ems_address`=0x0C123, `ems_write`=0, ready low for 5 cycles, `data_bus_out`=0x5A until `memory_read_n` rises.
- `pr[0]`=0x80; memory write of 0xA7 to 0xD0010 → `ems_write`=1, `ems_write_data`=0xA7, `ems_address`=0x00010, `data_bus_out_enable` never high.
- `pr[2]`=0x05 (disabled); memory read of 0xD8000 → no request, ready stays 1, no drive.
- No ack; TIMEOUT=255 → request high for 256 cycles, then ready=1 and read data 0xFF.
- Assert `reset_n` during REQ → request drops immediately, `pr` cleared, ready=1. An I/O write with `address_enable_n`=0 leaves `pr` unchanged.
